// File: rtl/stream_result_checker.sv
// Pairwise in-order checker for an actual-result stream against an expected stream.
// Each side is buffered in a small FIFO; pairs are compared as soon as both heads exist.
module stream_result_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic [WIDTH-1:0]   act_data,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [WIDTH-1:0]   exp_data,
  input  logic               exp_valid,
  output logic               exp_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [COUNT_W-1:0] mismatch_count,
  output logic               err_valid,
  output logic [COUNT_W-1:0] first_err_index,
  output logic [WIDTH-1:0]   first_err_act,
  output logic [WIDTH-1:0]   first_err_exp
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | accepting and comparing samples
  // DONE  | statistics frozen until next start
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [COUNT_W-1:0] CNT_ONE = 1;

  state_t             state;
  logic [COUNT_W-1:0] n_samples;
  logic [COUNT_W-1:0] act_cnt, exp_cnt, cmp_cnt;
  logic [AW:0]        act_wr, act_rd, exp_wr, exp_rd;
  logic [WIDTH-1:0]   act_mem [DEPTH];
  logic [WIDTH-1:0]   exp_mem [DEPTH];

  logic act_empty, act_full, exp_empty, exp_full;
  logic act_push, exp_push, pop, start_ok, differ;
  logic [WIDTH-1:0]   act_head, exp_head;
  logic [COUNT_W-1:0] mm_next;

  // Extra pointer MSB separates full (MSBs differ) from empty (all bits equal).
  assign act_empty = (act_wr == act_rd);
  assign exp_empty = (exp_wr == exp_rd);
  assign act_full  = (act_wr[AW] != act_rd[AW]) && (act_wr[AW-1:0] == act_rd[AW-1:0]);
  assign exp_full  = (exp_wr[AW] != exp_rd[AW]) && (exp_wr[AW-1:0] == exp_rd[AW-1:0]);

  assign act_ready = (state == RUN) && !act_full && (act_cnt < n_samples);
  assign exp_ready = (state == RUN) && !exp_full && (exp_cnt < n_samples);

  assign act_push = act_valid && act_ready;
  assign exp_push = exp_valid && exp_ready;
  assign pop      = (state == RUN) && !act_empty && !exp_empty;
  assign start_ok = start && (state != RUN);

  assign act_head = act_mem[act_rd[AW-1:0]];
  assign exp_head = exp_mem[exp_rd[AW-1:0]];
  assign differ   = (act_head != exp_head);
  assign mm_next  = (pop && differ && !(&mismatch_count)) ? mismatch_count + CNT_ONE
                                                          : mismatch_count;

  always_ff @(posedge clk) begin
    if (act_push) act_mem[act_wr[AW-1:0]] <= act_data;
    if (exp_push) exp_mem[exp_wr[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      n_samples       <= '0;
      act_cnt         <= '0;
      exp_cnt         <= '0;
      cmp_cnt         <= '0;
      act_wr          <= '0;
      act_rd          <= '0;
      exp_wr          <= '0;
      exp_rd          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch_count  <= '0;
      err_valid       <= 1'b0;
      first_err_index <= '0;
      first_err_act   <= '0;
      first_err_exp   <= '0;
    end else if (start_ok) begin
      n_samples       <= num_samples;
      act_cnt         <= '0;
      exp_cnt         <= '0;
      cmp_cnt         <= '0;
      act_wr          <= '0;
      act_rd          <= '0;
      exp_wr          <= '0;
      exp_rd          <= '0;
      mismatch_count  <= '0;
      err_valid       <= 1'b0;
      first_err_index <= '0;
      first_err_act   <= '0;
      first_err_exp   <= '0;
      if (num_samples == '0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
    end else if (state == RUN) begin
      if (act_push) begin
        act_wr  <= act_wr + PTR_ONE;
        act_cnt <= act_cnt + CNT_ONE;
      end
      if (exp_push) begin
        exp_wr  <= exp_wr + PTR_ONE;
        exp_cnt <= exp_cnt + CNT_ONE;
      end
      if (pop) begin
        act_rd         <= act_rd + PTR_ONE;
        exp_rd         <= exp_rd + PTR_ONE;
        cmp_cnt        <= cmp_cnt + CNT_ONE;
        mismatch_count <= mm_next;
        if (differ && !err_valid) begin
          err_valid       <= 1'b1;
          first_err_index <= cmp_cnt;
          first_err_act   <= act_head;
          first_err_exp   <= exp_head;
        end
        if (cmp_cnt + CNT_ONE == n_samples) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (mm_next == '0);
        end
      end
    end
  end

endmodule
